// File: rtl/xrv_if.sv
`default_nettype none
// xrv_if - instruction fetch unit: single-outstanding word fetch, 3-halfword
// realignment buffer and one-instruction output register.  Rev 1.0
module xrv_if #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstb,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] flush_addr,
    input  logic        id_jmp,
    input  logic [31:0] id_jmp_addr,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_is_compressed,
    output logic        inst_valid
);

    localparam logic [31:0] ALIGN4 = 32'hFFFF_FFFC;
    localparam logic [31:0] ALIGN2 = 32'hFFFF_FFFE;

    logic [31:0] fetch_addr;
    logic        drop;
    logic        skip_lo;
    logic [15:0] hbuf [3];
    logic [1:0]  cnt;
    logic [31:0] head_pc;
    logic        out_full;

    logic        ack_hit;
    logic        push;
    logic        hold_req;
    logic        redirect;
    logic        can_issue;
    logic        first_c;
    logic        req_n;
    logic        launch;
    logic [31:0] tgt;
    logic [31:0] fetch_addr_n;
    logic [15:0] in_p0;
    logic [15:0] in_p1;
    logic [1:0]  in_n;
    logic [1:0]  take;
    logic [1:0]  cnt_n;
    logic [2:0]  avail;
    logic [15:0] cv [5];
    logic [15:0] hbuf_n [3];

    assign inst_valid = out_full & ~stall & ~flush;
    assign ack_hit    = imem_req & imem_ack;
    assign push       = ack_hit & ~drop;
    assign hold_req   = imem_req & ~imem_ack;
    assign redirect   = flush | (id_jmp & inst_valid);
    assign tgt        = flush ? flush_addr : id_jmp_addr;
    assign can_issue  = ~out_full | ~stall;

    assign in_p0 = skip_lo ? imem_rdata[31:16] : imem_rdata[15:0];
    assign in_p1 = imem_rdata[31:16];
    assign in_n  = push ? (skip_lo ? 2'd1 : 2'd2) : 2'd0;
    assign avail = {1'b0, cnt} + {1'b0, in_n};

    // Buffered parcels followed by this cycle's incoming parcels, so data
    // can issue in the same cycle it is acknowledged.
    always_comb begin
        case (cnt)
            2'd0:    cv = '{in_p0, in_p1, 16'h0, 16'h0, 16'h0};
            2'd1:    cv = '{hbuf[0], in_p0, in_p1, 16'h0, 16'h0};
            2'd2:    cv = '{hbuf[0], hbuf[1], in_p0, in_p1, 16'h0};
            default: cv = '{hbuf[0], hbuf[1], hbuf[2], in_p0, in_p1};
        endcase
    end

    assign first_c = (cv[0][1:0] != 2'b11);

    always_comb begin
        take = 2'd0;
        if (can_issue) begin
            if ((avail != 3'd0) && first_c) begin
                take = 2'd1;
            end else if (avail >= 3'd2) begin
                take = 2'd2;
            end
        end
    end

    always_comb begin
        case (take)
            2'd1:    hbuf_n = '{cv[1], cv[2], cv[3]};
            2'd2:    hbuf_n = '{cv[2], cv[3], cv[4]};
            default: hbuf_n = '{cv[0], cv[1], cv[2]};
        endcase
    end

    // Requests are only launched with at most one parcel left, so the sum
    // of buffer and incoming parcels never exceeds three.
    assign cnt_n  = avail[1:0] - take;
    assign req_n  = hold_req | redirect | ~cnt_n[1];
    assign launch = req_n & ~hold_req;

    always_comb begin
        if (redirect) begin
            fetch_addr_n = tgt & ALIGN4;
        end else if (push) begin
            fetch_addr_n = fetch_addr + 32'd4;
        end else begin
            fetch_addr_n = fetch_addr;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            imem_req   <= 1'b0;
            imem_addr  <= RESET_PC & ALIGN4;
            fetch_addr <= RESET_PC & ALIGN4;
        end else begin
            imem_req   <= req_n;
            fetch_addr <= fetch_addr_n;
            if (launch) begin
                imem_addr <= fetch_addr_n;
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            drop    <= 1'b0;
            skip_lo <= RESET_PC[1];
            cnt     <= 2'd0;
            head_pc <= RESET_PC & ALIGN2;
            hbuf    <= '{16'h0, 16'h0, 16'h0};
        end else if (redirect) begin
            // A request already in flight keeps its address; its data is dropped.
            drop    <= hold_req;
            skip_lo <= tgt[1];
            cnt     <= 2'd0;
            head_pc <= tgt & ALIGN2;
        end else begin
            if (ack_hit) begin
                drop <= 1'b0;
            end
            if (push) begin
                skip_lo <= 1'b0;
            end
            cnt     <= cnt_n;
            hbuf    <= hbuf_n;
            head_pc <= head_pc + {29'd0, take, 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            out_full           <= 1'b0;
            inst               <= 32'h0;
            inst_pc            <= 32'h0;
            inst_is_compressed <= 1'b0;
        end else if (redirect) begin
            out_full <= 1'b0;
        end else if (can_issue) begin
            out_full <= (take != 2'd0);
            if (take != 2'd0) begin
                inst               <= (take == 2'd1) ? {16'h0, cv[0]} : {cv[1], cv[0]};
                inst_pc            <= head_pc;
                inst_is_compressed <= (take == 2'd1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_xrv_if.sv
`default_nettype none
// tb_xrv_if - directed tables plus randomized run against an instruction-stream model.
module tb_xrv_if;

    logic        clk = 1'b0;
    logic        rstb;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        flush;
    logic [31:0] flush_addr;
    logic        id_jmp;
    logic [31:0] id_jmp_addr;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_is_compressed;
    logic        inst_valid;

    logic        ack_en;
    logic [31:0] mem [1024];

    always #5 clk = ~clk;

    assign imem_ack   = imem_req & ack_en;
    assign imem_rdata = mem[imem_addr[11:2]];

    xrv_if #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rstb(rstb),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall(stall), .flush(flush), .flush_addr(flush_addr),
        .id_jmp(id_jmp), .id_jmp_addr(id_jmp_addr),
        .inst(inst), .inst_pc(inst_pc), .inst_is_compressed(inst_is_compressed),
        .inst_valid(inst_valid)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        c;
    } vec_t;

    vec_t v1 [4];
    vec_t v2 [3];

    int          n_total = 0;
    int          n_bad   = 0;
    int          n_valid = 0;
    logic [31:0] exp_pc;
    logic        prev_hold;
    logic [31:0] prev_addr;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%h required=%h", nm, act, req);
        end
    endtask

    function automatic logic [15:0] half_at(input logic [31:0] a);
        logic [31:0] w;
        w = mem[a[11:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    // Instruction found in memory at a given pc, raw and zero-extended if 16-bit.
    function automatic logic [31:0] inst_at(input logic [31:0] a);
        logic [15:0] h0;
        h0 = half_at(a);
        if (h0[1:0] != 2'b11) return {16'h0, h0};
        return {half_at(a + 32'd2), h0};
    endfunction

    // One clock: settle inputs, score the presented instruction, advance.
    task automatic step();
        logic [31:0] e;
        logic        ec;
        #1;
        if (rstb) begin
            check("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
            if (prev_hold) begin
                check("req_held", {31'd0, imem_req}, 32'd1);
                check("addr_held", imem_addr, prev_addr);
            end
            if (inst_valid) begin
                e  = inst_at(exp_pc);
                ec = (e[1:0] != 2'b11);
                check("stream_pc", inst_pc, exp_pc);
                check("stream_inst", inst, e);
                check("stream_c", {31'd0, inst_is_compressed}, {31'd0, ec});
                n_valid++;
                if (id_jmp) exp_pc = id_jmp_addr & 32'hFFFF_FFFE;
                else        exp_pc = exp_pc + (ec ? 32'd2 : 32'd4);
            end
            if (flush) exp_pc = flush_addr & 32'hFFFF_FFFE;
            prev_hold = imem_req & ~imem_ack;
            prev_addr = imem_addr;
        end
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   {31'd0, imem_req}, 32'd0);
        check({tag, "_addr"},  imem_addr, 32'd0);
        check({tag, "_inst"},  inst, 32'd0);
        check({tag, "_pc"},    inst_pc, 32'd0);
        check({tag, "_c"},     {31'd0, inst_is_compressed}, 32'd0);
        check({tag, "_valid"}, {31'd0, inst_valid}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic found;
        int   n0;

        v1[0] = '{32'h0, 32'h0000_0013, 1'b0};
        v1[1] = '{32'h4, 32'h0000_0013, 1'b0};
        v1[2] = '{32'h8, 32'h0000_0013, 1'b0};
        v1[3] = '{32'hC, 32'h0000_0013, 1'b0};
        v2[0] = '{32'h100, 32'h0000_4501, 1'b1};
        v2[1] = '{32'h102, 32'h00A0_0593, 1'b0};
        v2[2] = '{32'h106, 32'h0000_8082, 1'b1};

        for (int i = 0; i < 1024; i++) mem[i] = 32'h0000_0013;
        mem[10'h040] = 32'h0593_4501;
        mem[10'h041] = 32'h8082_00A0;
        mem[10'h043] = 32'h0000_4511;
        mem[10'h080] = 32'h4505_FFFF;
        mem[10'h100] = 32'h0010_0093;
        for (int i = 1; i < 16; i++) mem[10'h100 + i] = $urandom;

        stall = 0; flush = 0; flush_addr = 0; id_jmp = 0; id_jmp_addr = 0;
        ack_en = 1; rstb = 0; prev_hold = 0; prev_addr = 0; exp_pc = 0;
        #1;
        check_reset_outputs("rst");
        repeat (2) @(posedge clk);
        #2;
        rstb = 1;

        // Zero-wait NOP stream from RESET_PC
        check("c0_req", {31'd0, imem_req}, 32'd0);
        step();
        check("c1_req", {31'd0, imem_req}, 32'd1);
        check("c1_addr", imem_addr, 32'h0);
        check("c1_valid", {31'd0, inst_valid}, 32'd0);
        step();
        for (int i = 0; i < 4; i++) begin
            check("t1_valid", {31'd0, inst_valid}, 32'd1);
            check("t1_pc", inst_pc, v1[i].pc);
            check("t1_inst", inst, v1[i].ins);
            check("t1_c", {31'd0, inst_is_compressed}, {31'd0, v1[i].c});
            step();
        end

        // Mixed 16/32-bit stream with a straddling 32-bit instruction
        flush = 1; flush_addr = 32'h100;
        step();
        flush = 0;
        check("t2_req", {31'd0, imem_req}, 32'd1);
        check("t2_addr", imem_addr, 32'h100);
        step();
        for (int i = 0; i < 3; i++) begin
            check("t2_valid", {31'd0, inst_valid}, 32'd1);
            check("t2_pc", inst_pc, v2[i].pc);
            check("t2_inst", inst, v2[i].ins);
            check("t2_c", {31'd0, inst_is_compressed}, {31'd0, v2[i].c});
            step();
        end

        // Decode-stage jump to a halfword-aligned target
        flush = 1; flush_addr = 32'h100;
        step();
        flush = 0;
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (inst_valid && inst_pc == 32'h102) found = 1;
            else step();
        end
        check("t3_jal_seen", {31'd0, found}, 32'd1);
        id_jmp = 1; id_jmp_addr = 32'h202;
        step();
        id_jmp = 0;
        check("t3_req", {31'd0, imem_req}, 32'd1);
        check("t3_addr", imem_addr, 32'h200);
        check("t3_no_seq", {31'd0, inst_valid}, 32'd0);
        step();
        check("t3_valid", {31'd0, inst_valid}, 32'd1);
        check("t3_pc", inst_pc, 32'h202);
        check("t3_inst", inst, 32'h0000_4505);

        // Flush while the request to 0x10C waits three cycles for ack
        flush = 1; flush_addr = 32'h100;
        step();
        flush = 0;
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (imem_req && imem_addr == 32'h10C) found = 1;
            else step();
        end
        check("t4_req_seen", {31'd0, found}, 32'd1);
        ack_en = 0; flush = 1; flush_addr = 32'h400;
        step();
        flush = 0;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) ack_en = 1;
            check("t4_hold_req", {31'd0, imem_req}, 32'd1);
            check("t4_hold_addr", imem_addr, 32'h10C);
            check("t4_hold_valid", {31'd0, inst_valid}, 32'd0);
            step();
        end
        check("t4_refetch_req", {31'd0, imem_req}, 32'd1);
        check("t4_refetch_addr", imem_addr, 32'h400);
        check("t4_refetch_valid", {31'd0, inst_valid}, 32'd0);
        step();
        check("t4_valid", {31'd0, inst_valid}, 32'd1);
        check("t4_pc", inst_pc, 32'h400);
        check("t4_inst", inst, 32'h0010_0093);

        // Four-cycle stall with the 0x400 instruction on the output
        stall = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("t5_valid", {31'd0, inst_valid}, 32'd0);
            check("t5_pc", inst_pc, 32'h400);
            check("t5_inst", inst, 32'h0010_0093);
            step();
        end
        stall = 0;
        #1;
        check("t5_release_valid", {31'd0, inst_valid}, 32'd1);
        check("t5_release_pc", inst_pc, 32'h400);
        repeat (12) step();

        // Randomized traffic; memory changes only together with a flush
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        flush = 1; flush_addr = 32'h0;
        step();
        n0 = n_valid;
        for (int c = 0; c < 3000; c++) begin
            stall       = ($urandom_range(0, 3) == 0);
            ack_en      = ((c % 1000) < 400) ? 1'b1 : ($urandom_range(0, 9) < 6);
            flush       = ($urandom_range(0, 39) == 0);
            flush_addr  = $urandom;
            id_jmp      = ($urandom_range(0, 14) == 0);
            id_jmp_addr = $urandom;
            step();
        end
        check("rand_progress", {31'd0, (n_valid - n0) > 300}, 32'd1);

        // Reset in the middle of an unacknowledged request
        stall = 0; flush = 0; id_jmp = 0; ack_en = 0;
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (imem_req) found = 1;
            else step();
        end
        check("t6_pending", {31'd0, found}, 32'd1);
        rstb = 0;
        #1;
        check_reset_outputs("t6");
        @(posedge clk);
        #2;
        ack_en = 1; rstb = 1; prev_hold = 0; exp_pc = 32'h0;
        step();
        check("t6_req", {31'd0, imem_req}, 32'd1);
        check("t6_addr", imem_addr, 32'h0);
        n0 = n_valid;
        repeat (20) step();
        check("t6_progress", {31'd0, (n_valid - n0) >= 10}, 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/xrv_if.md
# xrv_if

Instruction fetch unit for the xrv core. Fetches 32-bit words from instruction memory over a single-outstanding req/ack port, realigns 16/32-bit parcels in a 3-halfword buffer, and presents one instruction per cycle to `xrv_id` on `inst`, `inst_pc`, `inst_is_compressed` and `inst_valid`. Redirects come from `id_jmp`/`id_jmp_addr` (decode-stage JAL) and `flush`/`flush_addr` (execute-stage branch/JALR). Compressed parcels are passed raw and zero-extended; RVC expansion is done downstream of this block.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset (bit 0 ignored).
- `clk`  in  1  clock.
- `rstb`  in  1  reset, asynchronous, active-low.
- `imem_req`  out  1  fetch request; held with stable `imem_addr` until `imem_ack`.
- `imem_addr`  out  32  word-aligned fetch address, bits[1:0] = 0.
- `imem_ack`  in  1  request accepted and `imem_rdata` valid this cycle; may assert in the same cycle as `imem_req`.
- `imem_rdata`  in  32  fetched word; parcel0 = [15:0] at `addr`, parcel1 = [31:16] at `addr+2`.
- `stall`  in  1  downstream hold; instruction is kept and not presented.
- `flush`  in  1  execute-stage redirect.
- `flush_addr`  in  32  redirect target.
- `id_jmp`  in  1  decode-stage redirect for the instruction presented this cycle.
- `id_jmp_addr`  in  32  its target.
- `inst`  out  32  instruction; compressed = {16'h0, parcel}.
- `inst_pc`  out  32  address of `inst`.
- `inst_is_compressed`  out  1  `inst[1:0] != 2'b11`.
- `inst_valid`  out  1  = `out_full & ~stall & ~flush`.

## Operation
- State: `fetch_addr` (word aligned), `req_pend`, `drop` (discard pending data), `skip_lo` (discard parcel0 of next word), buffer `buf[0..2]` halfwords with `cnt` (0-3) and `head_pc`, output register `out_full`/`inst`/`inst_pc`/`inst_is_compressed`.
- Request: `imem_req` asserts when `cnt` after this cycle's issue is ≤ 1, or when `drop`/a redirect leaves a refetch pending; deasserts the cycle after `imem_ack`. On each non-dropped ack, `fetch_addr += 4` (wraps at 2^32).
- Push: on ack with `drop=0`, append parcel0 and parcel1 (parcel1 only if `skip_lo`, then clear `skip_lo`). On ack with `drop=1`, discard data, clear `drop`.
- Issue (when output register empty or consumed, i.e. `~out_full | ~stall`): if `cnt≥1` and `buf[0][1:0]≠11` → compressed, consume 1, `head_pc += 2`; else if `cnt≥2` → 32-bit `{buf[1],buf[0]}`, consume 2, `head_pc += 4`; else `out_full` clears. Push and issue in the same cycle are allowed; net `cnt` never exceeds 3.
- Redirect (priority `flush` > `id_jmp`; `id_jmp` honoured only when `inst_valid`): target T; `fetch_addr ← T & ~3`, `head_pc ← T & ~1`, `skip_lo ← T[1]`, `cnt ← 0`, `out_full ← 0`; `drop ← 1` if a request is pending without ack this cycle (its address is held until ack, then refetch at T).
- `stall`: output register and buffer issue frozen; fetch continues while space allows.

## Timing
- Reset: `imem_req=0`, `imem_addr=RESET_PC&~3`, `inst=0`, `inst_pc=0`, `inst_is_compressed=0`, `inst_valid=0`; `cnt=0`, `drop=0`, `skip_lo=RESET_PC[1]`. Reset mid-transaction abandons the request; the memory side must tolerate it.
- First `imem_req` in the first cycle after `rstb` deasserts.
- Redirect at edge E: `imem_req` at new address in cycle E+1; zero-wait ack in E+1 → `inst_valid` in E+2 (ack-to-valid = 1 cycle).
- Steady state, zero-wait memory: one instruction per cycle for both 32-bit and 16-bit streams.
- A 32-bit instruction whose parcels straddle two words issues only once both parcels are buffered.
- `inst_valid` falls combinationally with `flush` or `stall`; `inst` holds its value.

## Test plan
- Zero-wait memory, RESET_PC=0, words 0x00000013 ×4 → `inst_valid` every cycle from cycle 2, `inst_pc` 0,4,8,C, `inst_is_compressed=0`.
- Mixed stream at 0x100: 16-bit 0x4501, 32-bit 0x00A00593 straddling 0x102–0x105, 16-bit 0x8082 → `inst_pc` 0x100/0x102/0x106, `inst` 0x00004501/0x00A00593/0x00008082, compressed 1/0/1.
- `id_jmp` with `id_jmp_addr=0x202` → next `imem_addr=0x200`, parcel0 discarded, first `inst_pc=0x202`; no sequential instruction after the JAL presented.
- `flush` to 0x400 while a request to 0x10C waits 3 cycles for ack → 0x10C held until ack, data dropped, next `imem_addr=0x400`, first `inst_pc=0x400`.
- `stall` high 4 cycles mid-stream → `inst_valid=0`, `inst`/`inst_pc` unchanged, `cnt≤3`, no instruction lost or duplicated after release.
- `rstb` low mid-transaction → all outputs to reset values immediately; refetch from RESET_PC after release.
